// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the forwarding/hazard controller.
// Entry layout is {valid, rd, regw, memread}.
`define FWD_ENTRY_W(aw) ((aw) + 3)

package fwd_pkg;

  localparam int FWD_RF = 0;

  function automatic int fsw_f(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/fwd_stage_entry.sv
// One slot of the destination shadow pipeline.
// Holds on hold_i, loads an all-zero bubble on bubble_i.
module fwd_stage_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] ent_q;
  logic [W-1:0] ent_d;

  always_comb begin
    ent_d = ent_q;
    if (!hold_i) begin
      ent_d = bubble_i ? '0 : d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign q_o = ent_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller with registered,
// EX-aligned bypass selects and a saturating stall counter.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NSRC       = 2,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16,
  localparam int FSW       = fsw_f(FWD_STAGES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid_i,
  input  logic [NSRC*REG_AW-1:0] id_rs_i,
  input  logic [NSRC-1:0]        id_rs_used_i,
  input  logic [REG_AW-1:0]      id_rd_i,
  input  logic                   id_regw_i,
  input  logic                   id_memread_i,
  input  logic                   mem_stall_i,
  input  logic                   flush_i,
  output logic                   stall_if_id_o,
  output logic                   bubble_ex_o,
  output logic [NSRC*FSW-1:0]    fwd_sel_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  localparam int EW = `FWD_ENTRY_W(REG_AW);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regw;
    logic              memread;
  } entry_t;

  entry_t             st_q [FWD_STAGES+1];
  entry_t             st_d [FWD_STAGES+1];
  logic [FWD_STAGES:0] bub;
  entry_t             id_e;
  logic [REG_AW-1:0]  rs [NSRC];

  logic               hz;
  logic               lu_raw;
  logic               load_use;
  logic               admit;

  logic [NSRC*FSW-1:0] sel_q;
  logic [NSRC*FSW-1:0] sel_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                found;

  function automatic logic live(input entry_t e);
    return e.valid && e.regw && (e.rd != '0);
  endfunction

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      rs[i] = id_rs_i[i*REG_AW +: REG_AW];
    end
  end

  assign id_e = '{valid:   1'b1,
                  rd:      id_rd_i,
                  regw:    id_regw_i,
                  memread: id_memread_i};

  // A load too young to bypass blocks any consumer still in ID
  always_comb begin
    hz = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      for (int j = 0; j < LOAD_LAT; j++) begin
        if (id_rs_used_i[i] && live(st_q[j]) &&
            st_q[j].memread && (st_q[j].rd == rs[i])) begin
          hz = 1'b1;
        end
      end
    end
  end

  assign lu_raw        = id_valid_i && hz;
  assign load_use      = lu_raw && !flush_i;
  assign admit         = id_valid_i && !flush_i && !load_use;
  assign stall_if_id_o = mem_stall_i || load_use;
  assign bubble_ex_o   = !mem_stall_i && lu_raw;

  always_comb begin
    for (int k = 0; k <= FWD_STAGES; k++) begin
      st_d[k] = '0;
      bub[k]  = 1'b0;
    end
    st_d[0] = id_e;
    bub[0]  = !admit;
    for (int k = 1; k <= FWD_STAGES; k++) begin
      st_d[k] = st_q[k-1];
    end
  end

  for (genvar k = 0; k <= FWD_STAGES; k++) begin : g_st
    fwd_stage_entry #(
      .W (EW)
    ) u_ent (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold_i   (mem_stall_i),
      .bubble_i (bub[k]),
      .d_i      (st_d[k]),
      .q_o      (st_q[k])
    );
  end

  // Lowest stage index is the youngest producer, so first hit wins
  always_comb begin
    sel_d = '0;
    found = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      sel_d[i*FSW +: FSW] = FSW'(FWD_RF);
      found = 1'b0;
      for (int j = 0; j < FWD_STAGES; j++) begin
        if (!found && id_rs_used_i[i] && live(st_q[j]) &&
            (st_q[j].rd == rs[i])) begin
          sel_d[i*FSW +: FSW] = FSW'(j + 1);
          found = 1'b1;
        end
      end
    end
    if (!admit) begin
      sel_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_use && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q <= '0;
      cnt_q <= '0;
    end else if (!mem_stall_i) begin
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  assign fwd_sel_o   = sel_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; a second instance with a
// 2-bit counter shares the stimulus to exercise saturation.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_regw;
  logic        id_memread;
  logic        mem_stall;
  logic        flush;
  logic        stall_if_id;
  logic        bubble_ex;
  logic [3:0]  fwd_sel;
  logic [15:0] stall_cnt;
  logic        stall2;
  logic        bubble2;
  logic [3:0]  fwd_sel2;
  logic [1:0]  stall_cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rs_used_i  (id_rs_used),
    .id_rd_i       (id_rd),
    .id_regw_i     (id_regw),
    .id_memread_i  (id_memread),
    .mem_stall_i   (mem_stall),
    .flush_i       (flush),
    .stall_if_id_o (stall_if_id),
    .bubble_ex_o   (bubble_ex),
    .fwd_sel_o     (fwd_sel),
    .stall_cnt_o   (stall_cnt)
  );

  fwd_hazard_ctrl #(.CNT_W(2)) dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rs_used_i  (id_rs_used),
    .id_rd_i       (id_rd),
    .id_regw_i     (id_regw),
    .id_memread_i  (id_memread),
    .mem_stall_i   (mem_stall),
    .flush_i       (flush),
    .stall_if_id_o (stall2),
    .bubble_ex_o   (bubble2),
    .fwd_sel_o     (fwd_sel2),
    .stall_cnt_o   (stall_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [4:0] r1, input logic [4:0] r2,
                     input logic [1:0] used, input logic [4:0] rd,
                     input logic regw, input logic ld);
    id_valid   = 1'b1;
    id_rs      = {r2, r1};
    id_rs_used = used;
    id_rd      = rd;
    id_regw    = regw;
    id_memread = ld;
  endtask

  task automatic nop();
    id_valid   = 1'b0;
    id_rs      = '0;
    id_rs_used = '0;
    id_rd      = '0;
    id_regw    = 1'b0;
    id_memread = 1'b0;
  endtask

  task automatic drain();
    nop();
    repeat (4) cyc();
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_stall = 1'b0;
    flush     = 1'b0;
    nop();
    repeat (2) cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_stall", stall_if_id, 0);
    chk("rst_bubble", bubble_ex, 0);
    chk("rst_fwd", fwd_sel, 0);
    chk("rst_cnt", stall_cnt, 0);

    // add r3 ; sub r4,r3,r1
    ins(5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
    cyc();
    ins(5'd3, 5'd1, 2'b11, 5'd4, 1'b1, 1'b0);
    #1;
    chk("b2b_nostall", stall_if_id, 0);
    cyc();
    chk("b2b_fwd", fwd_sel, 4'b0001);
    drain();

    // add r3 ; nop ; or r5,r3,r3
    ins(5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
    cyc();
    nop();
    cyc();
    ins(5'd3, 5'd3, 2'b11, 5'd5, 1'b1, 1'b0);
    cyc();
    chk("gap1_fwd", fwd_sel, 4'b1010);
    drain();

    // add r3 ; nop ; nop ; or r5,r3,r3
    ins(5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
    cyc();
    nop();
    repeat (2) cyc();
    ins(5'd3, 5'd3, 2'b11, 5'd5, 1'b1, 1'b0);
    cyc();
    chk("gap2_fwd", fwd_sel, 4'b0000);
    drain();

    // lw r2 ; add r6,r2,r2
    ins(5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1);
    cyc();
    ins(5'd2, 5'd2, 2'b11, 5'd6, 1'b1, 1'b0);
    #1;
    chk("lu_stall", stall_if_id, 1);
    chk("lu_bubble", bubble_ex, 1);
    cyc();
    chk("lu_release", stall_if_id, 0);
    chk("lu_bubble_fwd", fwd_sel, 0);
    cyc();
    chk("lu_fwd", fwd_sel, 4'b1010);
    chk("lu_cnt", stall_cnt, 1);
    drain();

    // load to r0 then consumer of r0
    ins(5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b1);
    cyc();
    ins(5'd0, 5'd0, 2'b11, 5'd7, 1'b1, 1'b0);
    #1;
    chk("r0_nostall", stall_if_id, 0);
    cyc();
    chk("r0_fwd", fwd_sel, 0);
    drain();

    // youngest wins: add r3 ; add r3 ; or r5,r3,r0
    ins(5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
    cyc();
    ins(5'd7, 5'd0, 2'b01, 5'd3, 1'b1, 1'b0);
    cyc();
    ins(5'd3, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0);
    cyc();
    chk("young_fwd", fwd_sel, 4'b0001);
    drain();

    // freeze with mem_stall, then release
    ins(5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
    cyc();
    ins(5'd3, 5'd1, 2'b11, 5'd4, 1'b1, 1'b0);
    cyc();
    chk("ms_pre_fwd", fwd_sel, 4'b0001);
    ins(5'd3, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0);
    mem_stall = 1'b1;
    #1;
    chk("ms_stall", stall_if_id, 1);
    chk("ms_bubble", bubble_ex, 0);
    repeat (3) cyc();
    chk("ms_hold_fwd", fwd_sel, 4'b0001);
    chk("ms_hold_cnt", stall_cnt, 1);
    mem_stall = 1'b0;
    cyc();
    chk("ms_post_fwd", fwd_sel, 4'b0110);
    drain();

    // flush during load-use
    ins(5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1);
    cyc();
    ins(5'd2, 5'd2, 2'b11, 5'd6, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_bubble", bubble_ex, 1);
    chk("fl_stall", stall_if_id, 0);
    cyc();
    flush = 1'b0;
    nop();
    #1;
    chk("fl_cnt", stall_cnt, 1);
    chk("fl_fwd", fwd_sel, 0);
    drain();

    // mem_stall over load-use
    ins(5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1);
    cyc();
    ins(5'd2, 5'd2, 2'b11, 5'd6, 1'b1, 1'b0);
    mem_stall = 1'b1;
    #1;
    chk("msl_stall", stall_if_id, 1);
    chk("msl_bubble", bubble_ex, 0);
    cyc();
    chk("msl_cnt", stall_cnt, 1);
    mem_stall = 1'b0;
    #1;
    chk("msl_lu_bubble", bubble_ex, 1);
    cyc();
    chk("msl_cnt_inc", stall_cnt, 2);
    drain();

    // reset mid-stall
    ins(5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1);
    cyc();
    ins(5'd2, 5'd2, 2'b11, 5'd6, 1'b1, 1'b0);
    #1;
    chk("rs_pre_stall", stall_if_id, 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rs_stall", stall_if_id, 0);
    chk("rs_bubble", bubble_ex, 0);
    chk("rs_fwd", fwd_sel, 0);
    chk("rs_cnt", stall_cnt, 0);
    chk("rs_cnt2", stall_cnt2, 0);
    drain();

    // five load-use stalls
    for (int n = 0; n < 5; n++) begin
      ins(5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1);
      cyc();
      ins(5'd2, 5'd2, 2'b11, 5'd6, 1'b1, 1'b0);
      repeat (2) cyc();
      drain();
      if (n == 2) begin
        chk("sat_cnt2_at3", stall_cnt2, 3);
      end
    end
    chk("sat_cnt16", stall_cnt, 5);
    chk("sat_cnt2", stall_cnt2, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
